pong_ball: RTL and testbench
============================

Name: pong_ball

Overview:
- Ball engine for the Pong display path; the consumer of the paddle renderers' current-position outputs (left and right `y_Atual`).
- Moves an 8x8 ball on a timed step and bounces it off the top/bottom walls and both paddles.
- Detects misses and keeps scores.
- Draws the ball into the VGA pixel stream.
- Answers Nios custom-instruction commands: serve, and status readback.

Parameters:
X_INIT, 316, ball x at reset/serve (left edge, pixels)
Y_INIT, 236, ball y at reset/serve (top edge, pixels)
SPEED, 2, pixels moved per step on each axis
STEP_TICKS, 20'd833333, clk_in cycles between steps
X_BAR_L, 10, left paddle left edge; paddle spans x 10..20
X_BAR_R, 620, right paddle left edge; paddle spans x 620..630
BAR_H, 90, paddle height; paddle spans y yBar..yBar+90
Y_TOP, 6, topmost legal ball y
Y_BOT, 472, bottommost legal ball pixel (ball y+7)

Ports:
clk_in  in  1  board clock
i_rst  in  1  asynchronous, active-high reset
clk_en  in  1  custom-instruction strobe, one cycle per command
cmd  in  1  sampled with clk_en: 0 = serve, 1 = read status
enablePong  in  1  game enable; 0 freezes the block
o_active  in  1  high while a visible pixel is drawn
o_x  in  10  current pixel x
o_y  in  9  current pixel y
yBarLeft  in  9  left paddle top y (left renderer's y_Atual)
yBarRight  in  9  right paddle top y (right renderer's y_Atual)
result  out  32  status word
done  out  1  one-cycle command-complete pulse
ball_x  out  10  current ball x
ball_y  out  9  current ball y
color  out  1  registered ball pixel

Behaviour:
- Reset: asynchronous, active-high. Ball at X_INIT/Y_INIT. dx=-SPEED, dy=+SPEED. State IDLE. Scores 0. Scored flag 0. Tick counter 0. step_pending 0. result=0, done=0, color=0.
- States:
  - IDLE = 0: ball parked, no ticks.
  - RUN = 1: ball moves.
  - SCORED = 2: one cycle only. Increments the scorer's 4-bit score (wraps 15->0), sets the scored flag, reloads X_INIT/Y_INIT, negates dx (serve goes toward the scorer), then -> IDLE.
- Serve: clk_en with cmd=0 in IDLE -> RUN on the next edge. Ignored in RUN or SCORED, but done still pulses.
- Tick counter: counts only in RUN with enablePong=1. At STEP_TICKS-1 it wraps to 0 and sets step_pending.
- Step application: on the first cycle with step_pending=1 and o_active=0, the new position is applied and step_pending clears. The ball never moves mid-line.
- Step arithmetic: nx = x+dx and ny = y+dy, in 11-bit signed.
- Walls:
  - ny <= Y_TOP -> y=Y_TOP, dy=+SPEED.
  - ny+7 >= Y_BOT -> y=Y_BOT-7, dy=-SPEED.
- Left paddle, when dx<0, x>=21, nx<=20, and ny+7>=yBarLeft and ny<=yBarLeft+BAR_H -> x=21, dx=+SPEED.
- Left miss: dx<0 and nx<0 -> right scores, state goes to SCORED.
- Right paddle, when dx>0, x+7<=619, nx+7>=620, and vertical overlap with yBarRight -> x=612, dx=-SPEED.
- Right miss: dx>0 and nx+7>639 -> left scores, state goes to SCORED.
- Wall and paddle bounces can occur in the same step.
- Status read: clk_en with cmd=1 latches result the next edge:
  - [9:0] ball_x
  - [18:10] ball_y
  - [20:19] state
  - [24:21] score_left
  - [28:25] score_right
  - [29] scored flag
  - [31:30] 0
- The read clears the scored flag.
- If a read and a SCORED cycle coincide, the read returns the pre-event snapshot and the flag ends set.
- done: high exactly one cycle, the cycle after clk_en, for every command, including while disabled. result holds until the next read.
- color: registered, value = o_active & enablePong & (ball_x <= o_x <= ball_x+7) & (ball_y <= o_y <= ball_y+7). Latency is 1 cycle.
- enablePong=0:
  - Counter, step_pending, state and position are frozen; color is 0.
  - Serve commands are ignored (done pulses).
  - Reads still return status.
- Reset mid-game returns everything to reset values immediately.

Test Plan:
- Reset, then serve with STEP_TICKS=4 and o_active=0 -> done pulses one cycle later. State=1. After one step: ball_x=314, ball_y=238.
- Ball at y=8, dy=-2 (one step gives 6) -> y=6, dy=+2. Ball at y=464, dy=+2 -> y=465, dy=-2.
- Ball x=22, dx=-2, yBarLeft=200, ball_y=250 -> x=21, dx=+2. Same setup with yBarLeft=0 -> continues to x=0, then miss -> score_right=1, ball at 316/236, state IDLE, dx=+2.
- Read after the miss -> result[28:25]=1, [29]=1. Second read -> [29]=0. Read in the SCORED cycle -> old snapshot returned, flag=1 afterwards.
- Step due while o_active=1 for 100 cycles -> position unchanged until the first o_active=0 cycle. Pixel (316,236) active -> color=1 one cycle later. Pixel (324,236) -> color=0.
- enablePong=0 in RUN, plus a serve command -> no movement, color=0, done pulses. Re-enable -> tick resumes from its frozen count. Assert i_rst mid-step -> all outputs at reset values.

Source files
------------

// File: rtl/pong_ball_if.sv
// Custom-instruction link between the Nios core and the pong ball engine.
// The core issues a one-cycle clk_en strobe with cmd; the engine answers
// with a one-cycle done pulse and, for status reads, a latched result word.
interface pong_ball_if;
  logic        clk_en;
  logic        cmd;
  logic [31:0] result;
  logic        done;

  modport master (output clk_en, output cmd, input result, input done);
  modport slave  (input clk_en, input cmd, output result, output done);
endinterface

// File: rtl/pong_ball.sv
// Pong ball engine: moves an 8x8 ball on a timed step, bounces it off the
// walls and both paddles, keeps the score, draws the ball into the pixel
// stream and answers serve / status custom-instruction commands.
module pong_ball #(
  parameter logic [9:0]  X_INIT     = 10'd316,
  parameter logic [8:0]  Y_INIT     = 9'd236,
  parameter logic [10:0] SPEED      = 11'd2,
  parameter logic [19:0] STEP_TICKS = 20'd833333,
  parameter logic [10:0] X_BAR_L    = 11'd10,
  parameter logic [10:0] X_BAR_R    = 11'd620,
  parameter logic [10:0] BAR_H      = 11'd90,
  parameter logic [10:0] Y_TOP      = 11'd6,
  parameter logic [10:0] Y_BOT      = 11'd472
) (
  input  logic       clk_in,
  input  logic       i_rst,
  pong_ball_if.slave ci,
  input  logic       enablePong,
  input  logic       o_active,
  input  logic [9:0] o_x,
  input  logic [8:0] o_y,
  input  logic [8:0] yBarLeft,
  input  logic [8:0] yBarRight,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic       color
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SCORED = 2'd2
  } state_t;

  // Geometry in signed 11-bit so that a step past x=0 shows up as negative.
  localparam logic signed [10:0] SPD_S    = $signed(SPEED);
  localparam logic signed [10:0] L_FACE_X = $signed(X_BAR_L + 11'd10);  // paddle right edge
  localparam logic signed [10:0] L_HIT_X  = $signed(X_BAR_L + 11'd11);  // ball parks just right of it
  localparam logic signed [10:0] R_FACE_X = $signed(X_BAR_R);
  localparam logic signed [10:0] R_LIMIT  = $signed(X_BAR_R - 11'd1);
  localparam logic signed [10:0] R_HIT_X  = $signed(X_BAR_R - 11'd8);   // ball right edge touches paddle
  localparam logic signed [10:0] SCR_MAX  = 11'sd639;
  localparam logic signed [10:0] BAR_H_S  = $signed(BAR_H);
  localparam logic signed [10:0] Y_TOP_S  = $signed(Y_TOP);
  localparam logic signed [10:0] Y_BOT_S  = $signed(Y_BOT);
  localparam logic [10:0]        Y_BOT_M7 = Y_BOT - 11'd7;

  state_t             state_r, state_s;
  logic [9:0]         x_r, x_s;
  logic [8:0]         y_r, y_s;
  logic               dx_neg_r, dx_neg_s, dy_neg_r, dy_neg_s;
  logic [3:0]         score_l_r, score_l_s, score_r_r, score_r_s;
  logic               scored_r, scored_s;
  logic [19:0]        tick_r, tick_s;
  logic               pend_r, pend_s;
  logic [31:0]        result_r;
  logic               done_r, color_r;

  logic signed [10:0] x_cur_s, y_cur_s, dx_s, dy_s, nx_s, ny_s, yl_s, yr_s;
  logic               hit_l_s, hit_r_s, miss_l_s, miss_r_s, wall_t_s, wall_b_s;
  logic               step_go_s, read_s, pix_s;

  // Candidate next position and every collision/miss condition for it.
  always_comb begin
    x_cur_s   = $signed({1'b0, x_r});
    y_cur_s   = $signed({2'b00, y_r});
    yl_s      = $signed({2'b00, yBarLeft});
    yr_s      = $signed({2'b00, yBarRight});
    dx_s      = dx_neg_r ? -SPD_S : SPD_S;
    dy_s      = dy_neg_r ? -SPD_S : SPD_S;
    nx_s      = x_cur_s + dx_s;
    ny_s      = y_cur_s + dy_s;
    hit_l_s   = dx_neg_r && (x_cur_s >= L_HIT_X) && (nx_s <= L_FACE_X)
                && (ny_s + 11'sd7 >= yl_s) && (ny_s <= yl_s + BAR_H_S);
    hit_r_s   = !dx_neg_r && (x_cur_s + 11'sd7 <= R_LIMIT) && (nx_s + 11'sd7 >= R_FACE_X)
                && (ny_s + 11'sd7 >= yr_s) && (ny_s <= yr_s + BAR_H_S);
    miss_l_s  = dx_neg_r && (nx_s < 11'sd0);
    miss_r_s  = !dx_neg_r && (nx_s + 11'sd7 > SCR_MAX);
    wall_t_s  = (ny_s <= Y_TOP_S);
    wall_b_s  = (ny_s + 11'sd7 >= Y_BOT_S);
    step_go_s = pend_r && !o_active;
    read_s    = ci.clk_en && ci.cmd;
    pix_s     = o_active && enablePong
                && ({1'b0, o_x} >= {1'b0, x_r}) && ({1'b0, o_x} <= ({1'b0, x_r} + 11'd7))
                && ({1'b0, o_y} >= {1'b0, y_r}) && ({1'b0, o_y} <= ({1'b0, y_r} + 10'd7));
  end

  // Next-state and datapath update; everything holds while the game is disabled.
  always_comb begin
    state_s   = state_r;
    x_s       = x_r;
    y_s       = y_r;
    dx_neg_s  = dx_neg_r;
    dy_neg_s  = dy_neg_r;
    score_l_s = score_l_r;
    score_r_s = score_r_r;
    tick_s    = tick_r;
    pend_s    = pend_r;
    if (read_s) begin
      scored_s = 1'b0;
    end else begin
      scored_s = scored_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (enablePong && ci.clk_en && !ci.cmd) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (enablePong) begin
          // Apply a due step only during blanking so the ball never tears mid-line.
          if (step_go_s) begin
            pend_s = 1'b0;
            if (miss_l_s || miss_r_s) begin
              state_s = ST_SCORED;
            end else begin
              if (hit_l_s) begin
                x_s      = L_HIT_X[9:0];
                dx_neg_s = 1'b0;
              end else if (hit_r_s) begin
                x_s      = R_HIT_X[9:0];
                dx_neg_s = 1'b1;
              end else begin
                x_s      = nx_s[9:0];
                dx_neg_s = dx_neg_r;
              end
              if (wall_t_s) begin
                y_s      = Y_TOP[8:0];
                dy_neg_s = 1'b0;
              end else if (wall_b_s) begin
                y_s      = Y_BOT_M7[8:0];
                dy_neg_s = 1'b1;
              end else begin
                y_s      = ny_s[8:0];
                dy_neg_s = dy_neg_r;
              end
            end
          end else begin
            pend_s = pend_r;
          end
          // A wrap requests the next step; it wins over a same-cycle clear.
          if (tick_r == STEP_TICKS - 20'd1) begin
            tick_s = 20'd0;
            pend_s = 1'b1;
          end else begin
            tick_s = tick_r + 20'd1;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_SCORED: begin
        if (enablePong) begin
          // Ball was moving left on a miss -> right player scored, serve goes right.
          if (dx_neg_r) begin
            score_r_s = score_r_r + 4'd1;
            dx_neg_s  = 1'b0;
          end else begin
            score_l_s = score_l_r + 4'd1;
            dx_neg_s  = 1'b1;
          end
          scored_s = 1'b1;
          x_s      = X_INIT;
          y_s      = Y_INIT;
          tick_s   = 20'd0;
          pend_s   = 1'b0;
          state_s  = ST_IDLE;
        end else begin
          state_s = ST_SCORED;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Ball position, direction, scores and step timer.
  always_ff @(posedge clk_in or posedge i_rst) begin
    if (i_rst) begin
      x_r       <= X_INIT;
      y_r       <= Y_INIT;
      dx_neg_r  <= 1'b1;
      dy_neg_r  <= 1'b0;
      score_l_r <= 4'd0;
      score_r_r <= 4'd0;
      scored_r  <= 1'b0;
      tick_r    <= 20'd0;
      pend_r    <= 1'b0;
    end else begin
      x_r       <= x_s;
      y_r       <= y_s;
      dx_neg_r  <= dx_neg_s;
      dy_neg_r  <= dy_neg_s;
      score_l_r <= score_l_s;
      score_r_r <= score_r_s;
      scored_r  <= scored_s;
      tick_r    <= tick_s;
      pend_r    <= pend_s;
    end
  end

  // Command response (snapshot of pre-update state) and registered ball pixel.
  always_ff @(posedge clk_in or posedge i_rst) begin
    if (i_rst) begin
      result_r <= 32'd0;
      done_r   <= 1'b0;
      color_r  <= 1'b0;
    end else begin
      done_r  <= ci.clk_en;
      color_r <= pix_s;
      if (read_s) begin
        result_r <= {2'b00, scored_r, score_r_r, score_l_r, state_r, y_r, x_r};
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign ci.result = result_r;
  assign ci.done   = done_r;
  assign ball_x    = x_r;
  assign ball_y    = y_r;
  assign color     = color_r;

endmodule

// File: tb/tb_pong_ball.sv
// Directed bench for pong_ball: plays one full rally (walls, both paddles,
// a left miss), checks status reads around the scoring cycle, the blanking
// rule for steps, the pixel output, freeze/resume and mid-game reset.
module tb_pong_ball;
  logic       clk_in_s     = 1'b0;
  logic       i_rst_s      = 1'b0;
  logic       enable_s     = 1'b1;
  logic       o_active_s   = 1'b0;
  logic [9:0] o_x_s        = 10'd0;
  logic [8:0] o_y_s        = 9'd0;
  logic [8:0] ybar_left_s  = 9'd350;
  logic [8:0] ybar_right_s = 9'd150;
  logic [9:0] ball_x_s;
  logic [8:0] ball_y_s;
  logic       color_s;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc     = 0;

  pong_ball_if ci_if ();

  pong_ball #(.STEP_TICKS(20'd4)) dut (
    .clk_in     (clk_in_s),
    .i_rst      (i_rst_s),
    .ci         (ci_if),
    .enablePong (enable_s),
    .o_active   (o_active_s),
    .o_x        (o_x_s),
    .o_y        (o_y_s),
    .yBarLeft   (ybar_left_s),
    .yBarRight  (ybar_right_s),
    .ball_x     (ball_x_s),
    .ball_y     (ball_y_s),
    .color      (color_s)
  );

  // Free-running board clock.
  always #5 clk_in_s = ~clk_in_s;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in_s);
    @(negedge clk_in_s);
    cyc++;
  endtask

  // With STEP_TICKS=4 and blanking, step k lands on the (1+4k)th edge after the serve edge.
  task automatic goto_step(input int k);
    while (cyc < 1 + 4 * k) tick();
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check_val({tag, "_x"}, 32'(ball_x_s), ex);
    check_val({tag, "_y"}, 32'(ball_y_s), ey);
  endtask

  task automatic do_cmd(input logic c);
    ci_if.cmd    = c;
    ci_if.clk_en = 1'b1;
    tick();
    ci_if.clk_en = 1'b0;
    check_val("done_pulse", 32'(ci_if.done), 32'd1);
  endtask

  task automatic serve();
    do_cmd(1'b0);
    cyc = 0;
  endtask

  task automatic check_status(input string tag, input int ex, input int ey, input int st,
                              input int sl, input int sr, input int flag);
    check_val({tag, "_x"},   32'(ci_if.result[9:0]),   ex);
    check_val({tag, "_y"},   32'(ci_if.result[18:10]), ey);
    check_val({tag, "_st"},  32'(ci_if.result[20:19]), st);
    check_val({tag, "_sl"},  32'(ci_if.result[24:21]), sl);
    check_val({tag, "_sr"},  32'(ci_if.result[28:25]), sr);
    check_val({tag, "_flg"}, 32'(ci_if.result[29]),    flag);
    check_val({tag, "_top"}, 32'(ci_if.result[31:30]), 0);
  endtask

  // Main directed sequence.
  initial begin
    ci_if.clk_en = 1'b0;
    ci_if.cmd    = 1'b0;
    #2 i_rst_s = 1'b1;
    @(negedge clk_in_s);
    check_pos("rst", 316, 236);
    check_val("rst_done", 32'(ci_if.done), 32'd0);
    check_val("rst_result", ci_if.result, 32'd0);
    check_val("rst_color", 32'(color_s), 32'd0);
    i_rst_s = 1'b0;
    tick();

    // Serve and first step.
    serve();
    tick();
    check_val("done_once", 32'(ci_if.done), 32'd0);
    do_cmd(1'b1);
    check_val("run_state", 32'(ci_if.result[20:19]), 32'd1);
    while (cyc < 4) tick();
    check_pos("pre_step", 316, 236);
    tick();
    check_pos("step1", 314, 238);

    // Bottom wall.
    goto_step(114); check_pos("s114", 88, 464);
    goto_step(115); check_pos("bot_wall", 86, 465);
    // Left paddle hit.
    goto_step(147); check_pos("s147", 22, 401);
    goto_step(148); check_pos("l_paddle", 21, 399);
    goto_step(149); check_pos("s149", 23, 397);
    // Top wall.
    goto_step(344); check_pos("s344", 413, 7);
    goto_step(345); check_pos("top_wall", 415, 6);
    goto_step(346); check_pos("s346", 417, 8);
    // Right paddle hit.
    goto_step(443); check_pos("s443", 611, 202);
    goto_step(444); check_pos("r_paddle", 612, 204);
    goto_step(445); check_pos("s445", 610, 206);
    ybar_left_s = 9'd0;
    // Bottom wall again, then slip past the raised left paddle.
    goto_step(575); check_pos("bot_wall2", 350, 465);
    goto_step(576); check_pos("s576", 348, 463);
    goto_step(740); check_pos("l_pass", 20, 135);
    goto_step(750); check_pos("s750", 0, 115);

    // Miss: the scoring cycle is visible on step 751's edge; read during it.
    goto_step(751); check_pos("miss_hold", 0, 115);
    do_cmd(1'b1);
    check_status("rd_scored", 0, 115, 2, 0, 0, 0);
    check_pos("reload", 316, 236);
    do_cmd(1'b1);
    check_status("rd_after", 316, 236, 0, 0, 1, 1);
    do_cmd(1'b1);
    check_val("flag_clear", 32'(ci_if.result[29]), 32'd0);

    // Step held off by active video; pixel output while parked.
    o_active_s = 1'b1;
    serve();
    repeat (5) tick();
    check_pos("active_hold", 316, 236);
    o_x_s = 10'd316; o_y_s = 9'd236; tick();
    check_val("pix_corner", 32'(color_s), 32'd1);
    o_x_s = 10'd323; o_y_s = 9'd243; tick();
    check_val("pix_far", 32'(color_s), 32'd1);
    o_x_s = 10'd324; o_y_s = 9'd236; tick();
    check_val("pix_past", 32'(color_s), 32'd0);
    while (cyc < 104) tick();
    check_pos("active_100", 316, 236);
    o_active_s = 1'b0;
    tick();
    check_pos("blank_step", 318, 234);
    while (cyc < 109) tick();
    check_pos("next_step", 320, 232);

    // Freeze mid-run (step counter sits at 1).
    enable_s = 1'b0;
    o_active_s = 1'b1; o_x_s = 10'd320; o_y_s = 9'd232;
    serve();
    repeat (20) tick();
    check_pos("frozen", 320, 232);
    check_val("frozen_color", 32'(color_s), 32'd0);
    do_cmd(1'b1);
    check_val("frozen_state", 32'(ci_if.result[20:19]), 32'd1);
    enable_s = 1'b1;
    o_active_s = 1'b0;
    repeat (3) tick();
    check_pos("resume_wait", 320, 232);
    tick();
    check_pos("resume_step", 322, 230);

    // Reset in the middle of the game.
    tick();
    i_rst_s = 1'b1;
    #1;
    check_pos("mid_rst", 316, 236);
    check_val("mid_rst_result", ci_if.result, 32'd0);
    check_val("mid_rst_done", 32'(ci_if.done), 32'd0);
    check_val("mid_rst_color", 32'(color_s), 32'd0);
    @(negedge clk_in_s);
    i_rst_s = 1'b0;
    tick();

    // Serve while disabled in IDLE is ignored.
    enable_s = 1'b0;
    serve();
    repeat (8) tick();
    do_cmd(1'b1);
    check_status("dis_serve", 316, 236, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
